sync_fifo_ctrl: RTL and testbench
=================================

SYNC_FIFO_CTRL -- requirements
Module: sync_fifo_ctrl

Interface
REQ-001 SHALL have parameter data_width, default 8, word width in bits.
REQ-002 SHALL have parameter depth, default 16, storage entries; power of two, minimum 4.
REQ-003 SHALL have parameter af_level, default 14, almost_full threshold, in the range 1..depth.
REQ-004 SHALL have parameter ae_level, default 2, almost_empty threshold, in the range 0..depth-1.
REQ-005 SHALL have parameter fwft, default 0, read mode: 0 standard, 1 first-word fall-through.
REQ-006 SHALL have one clock and an asynchronous active-high reset: clk in 1, the single clock, rising edge; rst in 1, asynchronous active-high reset.
REQ-007 SHALL have clr, in, 1 bit, synchronous flush.
REQ-008 SHALL have data_in, in, data_width bits, write data; and w_en, in, 1 bit, write request.
REQ-009 SHALL have r_en, in, 1 bit, read request (pop in FWFT mode).
REQ-010 SHALL have data_out, out, data_width bits, read data, registered.
REQ-011 SHALL have full, out, 1 bit, and empty, out, 1 bit, registered status flags.
REQ-012 SHALL have almost_full, out, 1 bit, and almost_empty, out, 1 bit, threshold flags.
REQ-013 SHALL have count, out, $clog2(depth)+1 bits, occupancy.
REQ-014 SHALL have overflow, out, 1 bit, and underflow, out, 1 bit, sticky error flags.

Function
REQ-015 SHALL use binary read/write pointers of $clog2(depth)+1 bits, wrapping modulo 2*depth; the address is the low $clog2(depth) bits.
REQ-016 SHALL accept a write on an edge with w_en=1, full=0, clr=0: store data_in, advance wptr.
REQ-017 SHALL reject w_en=1 while full=1 (storage and wptr unchanged, even with a concurrent read) and set overflow.
REQ-018 SHALL reject r_en=1 while empty=1 (pointers and data_out unchanged, even with a concurrent write) and set underflow.
REQ-019 SHALL update count only on edges: +1 for an accepted write alone, -1 for an accepted read alone, unchanged for both or neither; count never exceeds depth.
REQ-020 SHALL drive full=(count==depth), empty=(count==0 in standard mode), almost_full=(count>=af_level), almost_empty=(count<=ae_level), all valid in the same cycle as count.
REQ-021 When fwft=0, SHALL make the head word appear on data_out one edge after r_en is accepted; otherwise data_out holds its value.
REQ-022 When fwft=1, SHALL keep the head word presented on data_out from an output register whenever empty=0; an accepted r_en pops it, and the next word appears on the same edge when available.
REQ-023 When fwft=1, SHALL implement a two-state output FSM: OUT_EMPTY->OUT_VALID on the edge after storage holds a word; OUT_VALID->OUT_EMPTY on a pop with no further word; otherwise stay.
REQ-024 When fwft=1, SHALL count the output-register word in count; for a write into an empty FIFO at edge k, count=1 after edge k and empty=0 only after edge k+1.
REQ-025 SHALL handle wrap-around through index depth-1 -> 0 with no loss or duplication of data.
REQ-026 SHALL give clr priority over w_en and r_en: pointers, count, overflow, underflow and FSM go to 0/OUT_EMPTY; empty=1, almost_empty=1, full=0; data_out holds.
REQ-027 SHALL hold overflow and underflow at 1 until rst or clr.

Reset
REQ-028 While rst=1, SHALL asynchronously force pointers=0, count=0, data_out=0, full=0, almost_full=0, empty=1, almost_empty=1, overflow=0, underflow=0, FSM=OUT_EMPTY.
REQ-029 SHALL leave memory contents unreset and never observable before being written.
REQ-030 SHALL apply reset asserted mid-transfer immediately, discarding in-flight reads and writes; the first edge after release behaves as from empty.

Verification
REQ-031 SHALL cover: fwft=0, depth=16; write 0x01..0x10 -> full=1 and almost_full=1 after the 16th edge; 17th write -> overflow=1, count=16.
REQ-032 SHALL cover: fwft=0; read all 16 words -> data_out=0x01..0x10 in order, each one edge after r_en; empty=1 after the last read; an extra r_en -> underflow=1, data_out stays 0x10.
REQ-033 SHALL cover: fwft=1; write 0xA5 into an empty FIFO at edge k -> count=1 after edge k, data_out=0xA5 and empty=0 after edge k+1, with no r_en required.
REQ-034 SHALL cover: count=8; w_en=r_en=1 for 40 cycles -> count stays 8, pointers wrap, output sequence matches input order.
REQ-035 SHALL cover: count=5 with overflow=1, then assert clr together with w_en=1 -> count=0, empty=1, overflow=0, write discarded.
REQ-036 SHALL cover: rst asserted between edges while count=3 -> empty=1, count=0, data_out=0 immediately, before the next edge.

Source files
------------

// File: rtl/sync_fifo_ctrl.sv
// ============================================================================
// Module      : sync_fifo_ctrl
// Description : Single-clock FIFO controller with registered status flags,
//               sticky error flags and optional first-word fall-through.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_ctrl #(
  parameter int data_width = 8,
  parameter int depth      = 16,
  parameter int af_level   = 14,
  parameter int ae_level   = 2,
  parameter int fwft       = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic [data_width-1:0]   data_in,
  input  logic                    w_en,
  input  logic                    r_en,
  output logic [data_width-1:0]   data_out,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(depth):0]  count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int               c_aw    = $clog2(depth);
  localparam logic [c_aw:0]    c_one   = (c_aw+1)'(1);
  localparam logic [c_aw:0]    c_depth = (c_aw+1)'(depth);
  localparam logic [c_aw:0]    c_af    = (c_aw+1)'(af_level);
  localparam logic [c_aw:0]    c_ae    = (c_aw+1)'(ae_level);

  typedef enum logic [0:0] {
    OUT_EMPTY = 1'b0,
    OUT_VALID = 1'b1
  } out_state_t;

  out_state_t            r_state;
  out_state_t            w_state_nxt;
  logic [c_aw:0]         r_wptr;
  logic [c_aw:0]         r_rptr;
  logic [c_aw:0]         w_count_nxt;
  logic                  w_empty_nxt;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_store_has;
  logic                  w_load;
  logic [data_width-1:0] r_mem [depth];

  assign w_wr_acc    = w_en & ~full  & ~clr;
  assign w_rd_acc    = r_en & ~empty & ~clr;
  assign w_store_has = (r_rptr != r_wptr);

  // In FWFT mode the output register is refilled whenever it is free or popped.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    if (fwft != 0) begin
      w_load = ~clr & w_store_has & ((r_state == OUT_EMPTY) | w_rd_acc);
      if (clr) begin
        w_state_nxt = OUT_EMPTY;
      end else begin
        case (r_state)
          OUT_EMPTY: if (w_store_has)             w_state_nxt = OUT_VALID;
          OUT_VALID: if (w_rd_acc & ~w_store_has) w_state_nxt = OUT_EMPTY;
          default:                                w_state_nxt = OUT_EMPTY;
        endcase
      end
    end else begin
      w_load = w_rd_acc;
    end
  end

  always_comb begin
    w_count_nxt = count;
    if (clr) begin
      w_count_nxt = '0;
    end else if (w_wr_acc & ~w_rd_acc) begin
      w_count_nxt = count + c_one;
    end else if (w_rd_acc & ~w_wr_acc) begin
      w_count_nxt = count - c_one;
    end
    if (fwft != 0) begin
      w_empty_nxt = (w_state_nxt == OUT_EMPTY);
    end else begin
      w_empty_nxt = (w_count_nxt == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= OUT_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      data_out     <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (clr) begin
        r_wptr    <= '0;
        r_rptr    <= '0;
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        if (w_wr_acc) r_wptr <= r_wptr + c_one;
        if (w_load) begin
          r_rptr   <= r_rptr + c_one;
          data_out <= r_mem[r_rptr[c_aw-1:0]];
        end
        if (w_en & full)  overflow  <= 1'b1;
        if (r_en & empty) underflow <= 1'b1;
      end
      count        <= w_count_nxt;
      full         <= (w_count_nxt == c_depth);
      empty        <= w_empty_nxt;
      almost_full  <= (w_count_nxt >= c_af);
      almost_empty <= (w_count_nxt <= c_ae);
    end
  end

  // Storage is deliberately left without reset; it is only read after a write.
  always_ff @(posedge clk) begin
    if (w_wr_acc & ~rst) begin
      r_mem[r_wptr[c_aw-1:0]] <= data_in;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_ctrl.sv
// ============================================================================
// Module      : tb_sync_fifo_ctrl
// Description : Bench driving a standard and a FWFT instance with shared
//               stimulus, checked against queue-based reference models.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_fifo_ctrl;

  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic       w_en;
  logic       r_en;
  logic [7:0] data_in;

  logic [7:0] s_dout, f_dout;
  logic [4:0] s_count, f_count;
  logic       s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  logic       f_full, f_empty, f_af, f_ae, f_ovf, f_udf;

  int total = 0;
  int bad   = 0;

  logic [7:0] s_q[$];
  logic [7:0] f_q[$];
  logic [7:0] m_s_dout, m_f_dout;
  logic       m_s_ovf, m_s_udf, m_f_ovf, m_f_udf, m_f_valid;

  always #5 clk = ~clk;

  sync_fifo_ctrl #(.data_width(8), .depth(DEPTH), .af_level(AF), .ae_level(AE), .fwft(0)) u_std (
    .clk(clk), .rst(rst), .clr(clr), .data_in(data_in), .w_en(w_en), .r_en(r_en),
    .data_out(s_dout), .full(s_full), .empty(s_empty), .almost_full(s_af),
    .almost_empty(s_ae), .count(s_count), .overflow(s_ovf), .underflow(s_udf)
  );

  sync_fifo_ctrl #(.data_width(8), .depth(DEPTH), .af_level(AF), .ae_level(AE), .fwft(1)) u_fwft (
    .clk(clk), .rst(rst), .clr(clr), .data_in(data_in), .w_en(w_en), .r_en(r_en),
    .data_out(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_af),
    .almost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_udf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    s_q.delete();
    f_q.delete();
    m_s_dout  = '0;
    m_f_dout  = '0;
    m_s_ovf   = 1'b0;
    m_s_udf   = 1'b0;
    m_f_ovf   = 1'b0;
    m_f_udf   = 1'b0;
    m_f_valid = 1'b0;
  endtask

  // One clock edge of both reference FIFOs, using occupancy before the edge.
  task automatic model_edge();
    int s_n = s_q.size();
    int f_n = f_q.size() + (m_f_valid ? 1 : 0);
    if (clr) begin
      s_q.delete();
      f_q.delete();
      m_f_valid = 1'b0;
      m_s_ovf   = 1'b0;
      m_s_udf   = 1'b0;
      m_f_ovf   = 1'b0;
      m_f_udf   = 1'b0;
    end else begin
      if (w_en && s_n == DEPTH) m_s_ovf = 1'b1;
      if (r_en && s_n == 0)     m_s_udf = 1'b1;
      if (r_en && s_n > 0)      m_s_dout = s_q.pop_front();
      if (w_en && s_n < DEPTH)  s_q.push_back(data_in);

      if (w_en && f_n == DEPTH) m_f_ovf = 1'b1;
      if (r_en && !m_f_valid)   m_f_udf = 1'b1;
      if (!m_f_valid || r_en) begin
        if (f_q.size() > 0) begin
          m_f_dout  = f_q.pop_front();
          m_f_valid = 1'b1;
        end else begin
          m_f_valid = 1'b0;
        end
      end
      if (w_en && f_n < DEPTH) f_q.push_back(data_in);
    end
  endtask

  task automatic compare_all();
    int sn = s_q.size();
    int fn = f_q.size() + (m_f_valid ? 1 : 0);
    check("std_count", 32'(s_count), 32'(sn));
    check("std_flags", {s_full, s_empty, s_af, s_ae, s_ovf, s_udf},
          {sn == DEPTH, sn == 0, sn >= AF, sn <= AE, m_s_ovf, m_s_udf});
    check("std_dout", s_dout, m_s_dout);
    check("fwft_count", 32'(f_count), 32'(fn));
    check("fwft_flags", {f_full, f_empty, f_af, f_ae, f_ovf, f_udf},
          {fn == DEPTH, !m_f_valid, fn >= AF, fn <= AE, m_f_ovf, m_f_udf});
    check("fwft_dout", f_dout, m_f_dout);
  endtask

  task automatic cycle(input logic we, input logic re, input logic [7:0] d, input logic cl);
    @(negedge clk);
    w_en    = we;
    r_en    = re;
    data_in = d;
    clr     = cl;
    @(posedge clk);
    model_edge();
    #1 compare_all();
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; w_en = 1'b0; r_en = 1'b0; data_in = '0;
    model_reset();
    #2 compare_all();
    @(negedge clk);
    rst = 1'b0;

    // Fill with 0x01..0x10, then one write too many.
    for (int i = 1; i <= 16; i++) cycle(1'b1, 1'b0, 8'(i), 1'b0);
    check("fill_full", s_full, 1'b1);
    check("fill_af", s_af, 1'b1);
    cycle(1'b1, 1'b0, 8'h11, 1'b0);
    check("ovf_set", s_ovf, 1'b1);
    check("ovf_count", 32'(s_count), 32'd16);

    // Drain in order, then one read too many.
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b0, 1'b1, 8'h00, 1'b0);
      check("std_read_order", s_dout, 8'(i));
    end
    check("drain_empty", s_empty, 1'b1);
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    check("udf_set", s_udf, 1'b1);
    check("udf_dout_hold", s_dout, 8'h10);
    check("udf_ovf_sticky", s_ovf, 1'b1);

    // FWFT fall-through latency.
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    cycle(1'b1, 1'b0, 8'hA5, 1'b0);
    check("fwft_cnt_k", 32'(f_count), 32'd1);
    check("fwft_empty_k", f_empty, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    check("fwft_dout_k1", f_dout, 8'hA5);
    check("fwft_empty_k1", f_empty, 1'b0);

    // Steady state at count=8 with simultaneous read and write.
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 8'(8'h20 + i), 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, 8'(8'h40 + i), 1'b0);
    check("rw_count_std", 32'(s_count), 32'd8);
    check("rw_count_fwft", 32'(f_count), 32'd8);

    // Count 5 with overflow set, then clear together with a write.
    for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 8'(8'h80 + i), 1'b0);
    for (int i = 0; i < 11; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);
    check("pre_clr_count", 32'(s_count), 32'd5);
    check("pre_clr_ovf", s_ovf, 1'b1);
    cycle(1'b1, 1'b0, 8'hEE, 1'b1);
    check("clr_count", 32'(s_count), 32'd0);
    check("clr_empty", s_empty, 1'b1);
    check("clr_ovf", s_ovf, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    check("clr_fwft_discard", f_empty, 1'b1);

    // Randomized traffic alternating between fill-biased and drain-biased.
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 50; i++) begin
        int wp = (p % 2 == 0) ? 80 : 25;
        cycle($urandom_range(0, 99) < wp, $urandom_range(0, 99) >= wp,
              8'($urandom), $urandom_range(0, 59) == 0);
      end
    end

    // Asynchronous reset between edges with three words stored.
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'(8'hC0 + i), 1'b0);
    @(negedge clk);
    w_en = 1'b1; data_in = 8'hDD;
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("arst_empty", s_empty, 1'b1);
    check("arst_count", 32'(s_count), 32'd0);
    check("arst_dout", s_dout, 8'h00);
    check("arst_fwft_dout", f_dout, 8'h00);
    compare_all();
    @(negedge clk);
    rst = 1'b0; w_en = 1'b0;
    for (int i = 0; i < 40; i++)
      cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 8'($urandom), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
